// File: rtl/gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank.sv
// WIDTH-bit staging/commit register bank with load, bidirectional shift and per-bit set/clear.
// Optional even-parity output and sticky parity error: define GF180MCU_REGRSNQ_BANK_PARITY_EN.
module gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
  parameter bit               AUTO_COMMIT = 1'b0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             E,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  input  logic [WIDTH-1:0] SETN,
  input  logic [WIDTH-1:0] CLRN,
  input  logic             UPD,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QS,
  output logic             SO,
  output logic             PEND
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
  ,
  output logic             QP,
  output logic             PERR
`endif
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] f;

  // An unknown MODE while enabled must propagate as X rather than pick a branch.
  always_comb begin
    f = s_q;
    if (E) begin
      case (MODE)
        2'b00:   f = s_q;
        2'b01:   f = D;
        2'b10:   f = {s_q[WIDTH-2:0], SI};
        2'b11:   f = {SI, s_q[WIDTH-1:1]};
        default: f = {WIDTH{1'bx}};
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_override
      always_comb begin
        if (!CLRN[gi])      s_d[gi] = 1'b0;
        else if (!SETN[gi]) s_d[gi] = 1'b1;
        else                s_d[gi] = f[gi];
      end
    end
  endgenerate

  always_comb begin
    if (AUTO_COMMIT)
      q_d = s_d;
    else
      q_d = UPD ? s_q : q_q;
    pend_d = AUTO_COMMIT ? 1'b0 : (s_d != q_d);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s_q    <= RESET_VAL;
      q_q    <= RESET_VAL;
      pend_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      q_q    <= q_d;
      pend_q <= pend_d;
    end
  end

  assign Q    = q_q;
  assign QS   = s_q;
  assign PEND = pend_q;
  assign SO   = MODE[0] ? s_q[0] : s_q[WIDTH-1];

`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
  logic qp_q, qp_d;
  logic perr_q, perr_d;

  always_comb begin
    qp_d   = ^q_d;
    perr_d = perr_q | (qp_q != ^q_q);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      qp_q   <= ^RESET_VAL;
      perr_q <= 1'b0;
    end else begin
      qp_q   <= qp_d;
      perr_q <= perr_d;
    end
  end

  assign QP   = qp_q;
  assign PERR = perr_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank.sv
// Bench for the staging/commit register bank: one commit-controlled and one auto-commit instance
// share all stimulus and are checked against an arithmetic reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       CLK, RN, E, SI, UPD;
  logic [1:0] MODE;
  logic [7:0] D, SETN, CLRN;
  logic [7:0] Q, QS, Q_ac, QS_ac;
  logic       SO, PEND, SO_ac, PEND_ac;
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
  logic       QP, PERR, QP_ac, PERR_ac;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [7:0] m_s, m_q;
  logic       m_pend;

  gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank #(.WIDTH(8), .RESET_VAL(RV), .AUTO_COMMIT(1'b0)) dut (
    .CLK(CLK), .RN(RN), .E(E), .MODE(MODE), .D(D), .SI(SI), .SETN(SETN), .CLRN(CLRN),
    .UPD(UPD), .Q(Q), .QS(QS), .SO(SO), .PEND(PEND)
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
    , .QP(QP), .PERR(PERR)
`endif
  );

  gf180mcu_fd_sc_mcu7t5v0__regrsnq_bank #(.WIDTH(8), .RESET_VAL(RV), .AUTO_COMMIT(1'b1)) dut_ac (
    .CLK(CLK), .RN(RN), .E(E), .MODE(MODE), .D(D), .SI(SI), .SETN(SETN), .CLRN(CLRN),
    .UPD(UPD), .Q(Q_ac), .QS(QS_ac), .SO(SO_ac), .PEND(PEND_ac)
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
    , .QP(QP_ac), .PERR(PERR_ac)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_next(input logic [7:0] s);
    int f;
    f = s;
    if (E) begin
      case (MODE)
        2'd1:    f = D;
        2'd2:    f = ((s * 2) + SI) % 256;
        2'd3:    f = (s / 2) + (SI ? 128 : 0);
        default: f = s;
      endcase
    end
    // Clear beats set: a bit forced low by CLRN stays low whatever SETN says.
    return (8'(f) | ~SETN) & CLRN;
  endfunction

  function automatic logic ref_so(input logic [7:0] s);
    return MODE[0] ? s[0] : s[7];
  endfunction

  // Advance the model and the DUT by one rising edge; outputs sampled 1 time unit later.
  task automatic step();
    logic [7:0] nxt;
    nxt = ref_next(m_s);
    if (UPD) m_q = m_s;
    m_pend = (nxt != m_q);
    m_s = nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    E = 0; MODE = 2'b00; D = 8'h00; SI = 0; SETN = 8'hFF; CLRN = 8'hFF; UPD = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RN = 0;
    repeat (2) @(posedge CLK);
    #3;
    RN = 1;
    m_s = RV; m_q = RV; m_pend = 0;
    #1;
    n_checks++;
    if (QS !== RV || Q !== RV || PEND !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: QS=%h Q=%h PEND=%b required QS=%h Q=%h PEND=0", QS, Q, PEND, RV, RV);
    end
    n_checks++;
    if (Q_ac !== RV || PEND_ac !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ac: Q=%h PEND=%b required Q=%h PEND=0", Q_ac, PEND_ac, RV);
    end
    $display("reset: QS=%h Q=%h PEND=%b", QS, Q, PEND);
  endtask

  task automatic test_load_commit();
    idle_inputs();
    E = 1; MODE = 2'b01; D = 8'h5A;
    step();
    n_checks++;
    if (QS !== 8'h5A || Q !== 8'hA5 || PEND !== 1'b1) begin
      n_fail++;
      $display("FAIL load: QS=%h Q=%h PEND=%b required QS=5a Q=a5 PEND=1", QS, Q, PEND);
    end
    n_checks++;
    if (Q_ac !== 8'h5A || PEND_ac !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ac: Q=%h PEND=%b required Q=5a PEND=0", Q_ac, PEND_ac);
    end
    MODE = 2'b00; UPD = 1;
    step();
    n_checks++;
    if (Q !== 8'h5A || PEND !== 1'b0) begin
      n_fail++;
      $display("FAIL commit: Q=%h PEND=%b required Q=5a PEND=0", Q, PEND);
    end
    $display("load_commit: QS=%h Q=%h PEND=%b", QS, Q, PEND);
  endtask

  task automatic test_shift();
    logic [2:0] so_exp;
    idle_inputs();
    E = 1; MODE = 2'b01; D = 8'h81;
    step();
    MODE = 2'b10; SI = 1;
    so_exp = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (SO !== so_exp[2-k] || SO !== ref_so(m_s)) begin
        n_fail++;
        $display("FAIL shift_so[%0d]: SO=%b required %b", k, SO, so_exp[2-k]);
      end
      step();
    end
    n_checks++;
    if (QS !== 8'h0F) begin
      n_fail++;
      $display("FAIL shift_left: QS=%h required 0f", QS);
    end
    MODE = 2'b11; SI = 0;
    #1;
    n_checks++;
    if (SO !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_right_so: SO=%b required 1", SO);
    end
    step();
    n_checks++;
    if (QS !== 8'h07 || Q_ac !== 8'h07) begin
      n_fail++;
      $display("FAIL shift_right: QS=%h Q_ac=%h required 07", QS, Q_ac);
    end
    $display("shift: QS=%h SO=%b", QS, SO);
  endtask

  task automatic test_override();
    idle_inputs();
    CLRN = 8'h00;
    step();
    n_checks++;
    if (QS !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_all: QS=%h required 00", QS);
    end
    E = 1; MODE = 2'b01; D = 8'hFF; CLRN = 8'hFE; SETN = 8'hFC;
    step();
    n_checks++;
    if (QS !== 8'hFE) begin
      n_fail++;
      $display("FAIL clear_beats_set: QS=%h required fe", QS);
    end
    E = 0; CLRN = 8'hFF; SETN = 8'h7F;
    step();
    n_checks++;
    if (QS !== 8'hFE) begin
      n_fail++;
      $display("FAIL set_while_disabled: QS=%h required fe", QS);
    end
    $display("override: QS=%h", QS);
  endtask

  task automatic test_same_edge_commit();
    idle_inputs();
    E = 1; MODE = 2'b01; D = 8'h22;
    step();
    D = 8'h11; UPD = 1;
    step();
    n_checks++;
    if (Q !== 8'h22 || QS !== 8'h11 || PEND !== 1'b1) begin
      n_fail++;
      $display("FAIL same_edge: Q=%h QS=%h PEND=%b required Q=22 QS=11 PEND=1", Q, QS, PEND);
    end
    $display("same_edge: Q=%h QS=%h PEND=%b", Q, QS, PEND);
  endtask

  task automatic test_auto_commit();
    idle_inputs();
    E = 1; MODE = 2'b01; D = 8'hC3;
    step();
    n_checks++;
    if (Q_ac !== 8'hC3 || PEND_ac !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_commit: Q=%h PEND=%b required Q=c3 PEND=0", Q_ac, PEND_ac);
    end
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
    n_checks++;
    if (QP_ac !== 1'b0 || PERR_ac !== 1'b0 || PERR !== 1'b0) begin
      n_fail++;
      $display("FAIL parity: QP=%b PERR=%b required QP=0 PERR=0", QP_ac, PERR_ac);
    end
`endif
    $display("auto_commit: Q=%h PEND=%b", Q_ac, PEND_ac);
  endtask

  task automatic test_async_reset();
    idle_inputs();
    E = 1; MODE = 2'b01; D = 8'h3C;
    step();
    idle_inputs();
    #3;
    RN = 0;
    #1;
    n_checks++;
    if (QS !== RV || Q !== RV || PEND !== 1'b0 || Q_ac !== RV) begin
      n_fail++;
      $display("FAIL async_reset: QS=%h Q=%h PEND=%b required QS=a5 Q=a5 PEND=0", QS, Q, PEND);
    end
    $display("async_reset: QS=%h Q=%h PEND=%b", QS, Q, PEND);
    @(negedge CLK);
    RN = 1;
    m_s = RV; m_q = RV; m_pend = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      E    = 1'($urandom);
      MODE = 2'($urandom);
      D    = 8'($urandom);
      SI   = 1'($urandom);
      UPD  = ($urandom_range(0, 2) == 0);
      SETN = ($urandom_range(0, 3) == 0) ? ~(8'd1 << $urandom_range(0, 7)) : 8'hFF;
      CLRN = ($urandom_range(0, 3) == 0) ? ~(8'd1 << $urandom_range(0, 7)) : 8'hFF;
      #1;
      n_checks++;
      if (SO !== ref_so(m_s)) begin
        n_fail++;
        $display("FAIL rand_so[%0d]: SO=%b required %b", n, SO, ref_so(m_s));
      end
      step();
      n_checks++;
      if (QS !== m_s || Q !== m_q || PEND !== m_pend) begin
        n_fail++;
        $display("FAIL rand[%0d]: QS=%h Q=%h PEND=%b required QS=%h Q=%h PEND=%b",
                 n, QS, Q, PEND, m_s, m_q, m_pend);
      end
      n_checks++;
      if (Q_ac !== m_s || QS_ac !== m_s || PEND_ac !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_ac[%0d]: Q=%h PEND=%b required Q=%h PEND=0", n, Q_ac, PEND_ac, m_s);
      end
`ifdef GF180MCU_REGRSNQ_BANK_PARITY_EN
      n_checks++;
      if (QP !== ^m_q || PERR !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_parity[%0d]: QP=%b PERR=%b required QP=%b PERR=0", n, QP, PERR, ^m_q);
      end
`endif
      $display("rand[%0d]: E=%b MODE=%b QS=%h Q=%h PEND=%b", n, E, MODE, QS, Q, PEND);
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_shift();
    test_override();
    test_same_edge_commit();
    test_auto_commit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
